// File: rtl/axis_write_cmd.sv
// axis_write_cmd: command front-end for the stream-to-AXI write path.
//
// Accepts one (address, length) command, emits the ID / address / length
// words back-to-back on the config bus, then counts handshaked beats on the
// monitored stream and pulses done when the commanded length has been seen.
//
// Optional feature macro: AXIS_WRITE_CMD_TIMEOUT_EN
//   When defined, a TIMEOUT_WIDTH-bit stall watchdog runs in RUN and aborts
//   the command with a one-cycle error pulse if no beat is seen for
//   2^TIMEOUT_WIDTH consecutive RUN cycles. When undefined, error is tied low.
module axis_write_cmd #(
  parameter int unsigned CONFIG_ID     = 1,
  parameter int unsigned CONFIG_ADDR   = 23,
  parameter int unsigned CONFIG_DATA   = 24,
  parameter int unsigned CONFIG_AWIDTH = 5,
  parameter int unsigned CONFIG_DWIDTH = 32,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  // Command channel
  input  logic [CONFIG_DWIDTH-1:0] cmd_address,
  input  logic [CONFIG_DWIDTH-1:0] cmd_length,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  // Config bus (no back-pressure)
  output logic [CONFIG_AWIDTH-1:0] cfg_addr,
  output logic [CONFIG_DWIDTH-1:0] cfg_data,
  output logic                     cfg_valid,
  // Monitored data stream
  input  logic                     str_valid,
  input  logic                     str_ready,
  // Status
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    StIdle,
    StId,
    StAddr,
    StLen,
    StRun
  } state_e;

  localparam logic [CONFIG_AWIDTH-1:0] CfgAddrId   = CONFIG_AWIDTH'(CONFIG_ADDR);
  localparam logic [CONFIG_AWIDTH-1:0] CfgAddrData = CONFIG_AWIDTH'(CONFIG_DATA);
  localparam logic [CONFIG_DWIDTH-1:0] CfgIdWord   = CONFIG_DWIDTH'(CONFIG_ID);
  localparam logic [CONFIG_DWIDTH-1:0] CountOne    = CONFIG_DWIDTH'(1);

  state_e                   state_q, state_d;
  logic [CONFIG_DWIDTH-1:0] address_q, address_d;
  logic [CONFIG_DWIDTH-1:0] length_q, length_d;
  logic [CONFIG_DWIDTH-1:0] count_q, count_d;

  logic [CONFIG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
  logic [CONFIG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
  logic                     cfg_valid_q, cfg_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic cmd_fire;
  logic beat;

  // Ready is combinational so a new command can be taken in the done cycle.
  assign cmd_ready = ~rst & (state_q == StIdle);
  assign cmd_fire  = cmd_valid & cmd_ready;
  // Only beats seen while in RUN are counted.
  assign beat      = str_valid & str_ready & (state_q == StRun);

`ifdef AXIS_WRITE_CMD_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] stall_q, stall_d;
  logic                     error_q, error_d;
  logic                     stall_expired;

  assign stall_expired = (stall_q == {TIMEOUT_WIDTH{1'b1}});
`else
  // Width only matters when the watchdog is built in.
  logic unused_timeout_width;
  assign unused_timeout_width = ^TIMEOUT_WIDTH;
`endif

  // Next-state logic: command capture, config sequencing and beat counting.
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    length_d  = length_q;
    count_d   = count_q;
    done_d    = 1'b0;
`ifdef AXIS_WRITE_CMD_TIMEOUT_EN
    stall_d   = stall_q;
    error_d   = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          address_d = cmd_address;
          length_d  = cmd_length;
          count_d   = '0;
`ifdef AXIS_WRITE_CMD_TIMEOUT_EN
          stall_d   = '0;
`endif
          // Zero-length commands complete at once without touching the bus.
          if (cmd_length != '0) begin
            state_d = StId;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StId:   state_d = StAddr;
      StAddr: state_d = StLen;
      StLen:  state_d = StRun;
      StRun: begin
        if (beat) begin
          count_d = count_q + CountOne;
`ifdef AXIS_WRITE_CMD_TIMEOUT_EN
          stall_d = '0;
`endif
          if (count_d == length_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
`ifdef AXIS_WRITE_CMD_TIMEOUT_EN
        end else if (stall_expired) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so the config bus is registered.
  always_comb begin
    cfg_valid_d = 1'b0;
    cfg_addr_d  = '0;
    cfg_data_d  = '0;
    busy_d      = (state_d != StIdle);

    case (state_d)
      StId: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CfgAddrId;
        cfg_data_d  = CfgIdWord;
      end
      StAddr: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CfgAddrData;
        cfg_data_d  = address_q;
      end
      StLen: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CfgAddrData;
        cfg_data_d  = length_q;
      end
      default: ;
    endcase
  end

  // State and output registers; reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      address_q   <= '0;
      length_q    <= '0;
      count_q     <= '0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      length_q    <= length_d;
      count_q     <= count_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef AXIS_WRITE_CMD_TIMEOUT_EN
  // Stall watchdog and its error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      error_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
